seq_adder_sub: RTL and testbench

- Multi-cycle, parametrised adder/subtractor built as an iterative network unrolled in time.
- One SLICE-bit ripple slice is reused for WIDTH/SLICE clock cycles. A registered carry links each slice to the next.
- Adds subtract mode, signed-overflow detection and a start/busy/done handshake, none of which the purely combinational 4-bit adder has.
- Serves as the area-reduced arithmetic unit for the wider datapaths in later labs.

---
 rtl/seq_adder_sub.sv | 112 +++++++++++
 tb/tb_seq_adder_sub.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_sub.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice is reused for
// WIDTH/SLICE cycles, with a registered carry chaining the slices together.
// Subtract is done as A + ~B + 1. A start/busy/done handshake frames each operation.
module seq_adder_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, acc_q, acc_d;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, v_q, busy_q, done_q;

  int unsigned      shamt;
  logic [WIDTH-1:0] a_shift, b_shift, slice_mask, sum_w;
  logic [SLICE:0]   slice_sum;

  // Current slice sum and the accumulator with slice k replaced by it.
  always_comb begin
    shamt      = 32'(k_q) * SLICE;
    a_shift    = op_a_q >> shamt;
    b_shift    = op_b_q >> shamt;
    slice_sum  = {1'b0, a_shift[SLICE-1:0]} + {1'b0, b_shift[SLICE-1:0]}
               + {{SLICE{1'b0}}, carry_q};
    slice_mask = '0;
    slice_mask[SLICE-1:0] = '1;
    sum_w      = '0;
    sum_w[SLICE-1:0] = slice_sum[SLICE-1:0];
    acc_d      = (acc_q & ~(slice_mask << shamt)) | (sum_w << shamt);
  end

  // Control FSM, operand latching, slice iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            op_a_q  <= A;
            op_b_q  <= sub ? ~B : B;
            // Subtract supplies the +1 of the two's complement via the carry.
            carry_q <= sub ? 1'b1 : Cin;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          carry_q <= slice_sum[SLICE];
          k_q     <= k_q + KW'(1);
          if (k_q == KLast) begin
            s_q     <= acc_d;
            cout_q  <= slice_sum[SLICE];
            v_q     <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                       (acc_d[WIDTH-1] != op_a_q[WIDTH-1]);
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_adder_sub.sv
// Directed bench for seq_adder_sub (SLICE=4 main instance) plus a random
// sweep comparing SLICE=1, 4 and 16 instances against a reference sum.
module tb_seq_adder_sub;

  logic        clk = 1'b0;
  logic        reset, start, start_sw, sub, Cin;
  logic [15:0] A, B;

  logic [15:0] s4, s1, s16;
  logic        cout4, v4, busy4, done4;
  logic        cout1, v1, busy1, done1;
  logic        cout16, v16, busy16, done16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_adder_sub #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .S(s4), .Cout(cout4), .V(v4), .busy(busy4), .done(done4)
  );

  seq_adder_sub #(.WIDTH(16), .SLICE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start_sw), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .S(s1), .Cout(cout1), .V(v1), .busy(busy1), .done(done1)
  );

  seq_adder_sub #(.WIDTH(16), .SLICE(16)) u_s16 (
    .clk(clk), .reset(reset), .start(start_sw), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .S(s16), .Cout(cout16), .V(v16), .busy(busy16), .done(done16)
  );

  // Issue one operation on the SLICE=4 instance and observe it for 6 samples
  // (sample 0 is just after the start edge). Ends with the DUT back in idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, output int done_at, output int n_done,
                        output int busy_mask, output logic [15:0] s_mid);
    @(negedge clk);
    A = a; B = b; sub = s; Cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_at = -1; n_done = 0; busy_mask = 0; s_mid = '0;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (busy4) busy_mask |= (1 << cyc);
      if (done4) begin
        n_done++;
        done_at = cyc;
      end
      if (cyc == 2) s_mid = s4;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_sw = 1'b0;
    A = 16'hA5A5; B = 16'h5A5A; sub = 1'b0; Cin = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    tests++; if (s4 !== 16'h0) begin fails++; $display("FAIL reset_s: got %h expected 0000", s4); end
    tests++; if (cout4 !== 1'b0 || v4 !== 1'b0) begin
      fails++; $display("FAIL reset_cv: got cout=%b v=%b expected 0 0", cout4, v4);
    end
    tests++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL reset_hs: got busy=%b done=%b expected 0 0", busy4, done4);
    end
    tests++; if (busy1 !== 1'b0 || busy16 !== 1'b0 || s1 !== 16'h0 || s16 !== 16'h0) begin
      fails++; $display("FAIL reset_sweep: got busy1=%b busy16=%b s1=%h s16=%h expected 0",
                        busy1, busy16, s1, s16);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add();
    int da, nd, bm; logic [15:0] sm;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, da, nd, bm, sm);
    tests++; if (s4 !== 16'h5556) begin fails++; $display("FAIL add_s: got %h expected 5556", s4); end
    tests++; if (cout4 !== 1'b0 || v4 !== 1'b0) begin
      fails++; $display("FAIL add_cv: got cout=%b v=%b expected 0 0", cout4, v4);
    end
    tests++; if (bm !== 15) begin fails++; $display("FAIL add_busy: got mask %b expected 1111", bm); end
    tests++; if (da !== 4 || nd !== 1) begin
      fails++; $display("FAIL add_done: got at=%0d count=%0d expected at=4 count=1", da, nd);
    end
    tests++; if (sm !== 16'h0) begin fails++; $display("FAIL add_hold: got %h expected 0000", sm); end
  endtask

  task automatic test_add_wrap();
    int da, nd, bm; logic [15:0] sm;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, da, nd, bm, sm);
    tests++; if (s4 !== 16'h0000 || cout4 !== 1'b1 || v4 !== 1'b0) begin
      fails++; $display("FAIL wrap: got s=%h c=%b v=%b expected 0000 1 0", s4, cout4, v4);
    end
    tests++; if (sm !== 16'h5556) begin fails++; $display("FAIL wrap_hold: got %h expected 5556", sm); end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, da, nd, bm, sm);
    tests++; if (s4 !== 16'h8000 || cout4 !== 1'b0 || v4 !== 1'b1) begin
      fails++; $display("FAIL add_ovf: got s=%h c=%b v=%b expected 8000 0 1", s4, cout4, v4);
    end
  endtask

  task automatic test_sub();
    int da, nd, bm; logic [15:0] sm;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, da, nd, bm, sm);
    tests++; if (s4 !== 16'hFFFE || cout4 !== 1'b0 || v4 !== 1'b0) begin
      fails++; $display("FAIL sub_neg: got s=%h c=%b v=%b expected fffe 0 0", s4, cout4, v4);
    end
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, da, nd, bm, sm);
    tests++; if (s4 !== 16'h7FFF || cout4 !== 1'b1 || v4 !== 1'b1) begin
      fails++; $display("FAIL sub_ovf: got s=%h c=%b v=%b expected 7fff 1 1", s4, cout4, v4);
    end
    tests++; if (da !== 4 || nd !== 1) begin
      fails++; $display("FAIL sub_done: got at=%0d count=%0d expected at=4 count=1", da, nd);
    end
  endtask

  // start held through RUN and DONE while operands churn; only the start-edge
  // operands may count and only one done may appear.
  task automatic test_handshake();
    int nd, da; logic [15:0] res; logic rc, rv;
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; sub = 1'b0; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    nd = 0; da = -1; res = '0; rc = 1'bx; rv = 1'bx;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom); Cin = 1'($urandom);
      start = (cyc <= 5);
      @(posedge clk); #1;
      if (done4) begin
        nd++; da = cyc; res = s4; rc = cout4; rv = v4;
      end
    end
    tests++; if (nd !== 1 || da !== 4) begin
      fails++; $display("FAIL hs_done: got count=%0d at=%0d expected count=1 at=4", nd, da);
    end
    tests++; if (res !== 16'h3333 || rc !== 1'b0 || rv !== 1'b0) begin
      fails++; $display("FAIL hs_result: got s=%h c=%b v=%b expected 3333 0 0", res, rc, rv);
    end
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL hs_idle: got busy=%b expected 0", busy4); end
  endtask

  // Second start lands in the idle cycle right after the done pulse.
  task automatic test_back_to_back();
    int da, nd, bm; logic [15:0] sm;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, da, nd, bm, sm);
    tests++; if (s4 !== 16'h0100 || cout4 !== 1'b0) begin
      fails++; $display("FAIL b2b_first: got s=%h c=%b expected 0100 0", s4, cout4);
    end
    run_op(16'h1000, 16'h0001, 1'b1, 1'b0, da, nd, bm, sm);
    tests++; if (s4 !== 16'h0FFF || cout4 !== 1'b1 || v4 !== 1'b0) begin
      fails++; $display("FAIL b2b_second: got s=%h c=%b v=%b expected 0fff 1 0", s4, cout4, v4);
    end
    tests++; if (da !== 4 || nd !== 1 || bm !== 15) begin
      fails++; $display("FAIL b2b_timing: got at=%0d count=%0d mask=%b expected 4 1 1111",
                        da, nd, bm);
    end
  endtask

  task automatic test_reset_mid_run();
    int nd, da, bm; logic [15:0] sm;
    @(negedge clk);
    A = 16'h1234; B = 16'h0001; sub = 1'b0; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL abort_hs: got busy=%b done=%b expected 0 0", busy4, done4);
    end
    tests++; if (s4 !== 16'h0 || cout4 !== 1'b0 || v4 !== 1'b0) begin
      fails++; $display("FAIL abort_out: got s=%h c=%b v=%b expected 0000 0 0", s4, cout4, v4);
    end
    @(negedge clk); reset = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL abort_nodone: got %0d pulses expected 0", nd); end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, da, nd, bm, sm);
    tests++; if (s4 !== 16'h0002 || da !== 4) begin
      fails++; $display("FAIL after_abort: got s=%h at=%0d expected 0002 4", s4, da);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a, b, es; logic s, c, ec, ev; logic [16:0] full;
    int seen1, seen4, seen16;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); c = 1'($urandom);
      if (i == 0) begin a = 16'h7FFF; b = 16'h7FFF; s = 1'b0; c = 1'b1; end
      if (i == 1) begin a = 16'h8000; b = 16'h7FFF; s = 1'b1; c = 1'b0; end
      if (s) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
      else   full = {1'b0, a} + {1'b0, b} + {16'd0, c};
      es = full[15:0]; ec = full[16];
      ev = s ? ((a[15] != b[15]) && (es[15] != a[15])) : ((a[15] == b[15]) && (es[15] != a[15]));
      @(negedge clk);
      A = a; B = b; sub = s; Cin = c; start = 1'b1; start_sw = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start_sw = 1'b0;
      seen1 = 0; seen4 = 0; seen16 = 0;
      for (int cyc = 1; cyc <= 17; cyc++) begin
        @(posedge clk); #1;
        if (done1) begin
          seen1++; tests++;
          if (cyc != 16 || s1 !== es || cout1 !== ec || v1 !== ev) begin
            fails++; $display("FAIL sweep_s1: got at=%0d s=%h c=%b v=%b expected 16 %h %b %b",
                              cyc, s1, cout1, v1, es, ec, ev);
          end
        end
        if (done4) begin
          seen4++; tests++;
          if (cyc != 4 || s4 !== es || cout4 !== ec || v4 !== ev) begin
            fails++; $display("FAIL sweep_s4: got at=%0d s=%h c=%b v=%b expected 4 %h %b %b",
                              cyc, s4, cout4, v4, es, ec, ev);
          end
        end
        if (done16) begin
          seen16++; tests++;
          if (cyc != 1 || s16 !== es || cout16 !== ec || v16 !== ev) begin
            fails++; $display("FAIL sweep_s16: got at=%0d s=%h c=%b v=%b expected 1 %h %b %b",
                              cyc, s16, cout16, v16, es, ec, ev);
          end
        end
      end
      tests++;
      if (seen1 != 1 || seen4 != 1 || seen16 != 1) begin
        fails++; $display("FAIL sweep_count: got %0d %0d %0d done pulses expected 1 1 1",
                          seen1, seen4, seen16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
